// File: rtl/dcache_pkg.sv
// Shared geometry, FSM encoding and word-select helper for the L1 data cache.
package dcache_pkg;
    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 256;
    localparam int NUM_LINES      = 32;
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;
    localparam int OFFSET_W       = $clog2(LINE_W / 8);
    localparam int WSEL_W         = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W        = $clog2(NUM_LINES);
    localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_RESUME    = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                      input logic [WSEL_W-1:0] sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction
endpackage

// File: rtl/dcache_sram.sv
// Line storage: valid/dirty/tag/data per line, combinational read, synchronous
// full-line (refill) or single-word (store hit) write at the same index.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    input  logic               line_we,
    input  logic [TAG_W-1:0]   line_tag,
    input  logic [LINE_W-1:0]  line_data,
    input  logic               word_we,
    input  logic [WSEL_W-1:0]  word_sel,
    input  logic [WORD_W-1:0]  word_data,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line
);
    logic [NUM_LINES-1:0] valid_bits;
    logic [NUM_LINES-1:0] dirty_bits;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [LINE_W-1:0]    lines [NUM_LINES];

    assign rd_valid = valid_bits[idx];
    assign rd_dirty = dirty_bits[idx];
    assign rd_tag   = tags[idx];
    assign rd_line  = lines[idx];

    // Only the status bits need reset; tag/data are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (line_we) begin
            valid_bits[idx] <= 1'b1;
            dirty_bits[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_bits[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tags[idx]  <= line_tag;
            lines[idx] <= line_data;
        end else if (word_we) begin
            lines[idx][word_sel*WORD_W +: WORD_W] <= word_data;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller that
// freezes the pipeline on a miss while a dirty victim is flushed and the line refilled.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [WORD_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    state_t             state;
    state_t             next_state;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] idx;
    logic [WSEL_W-1:0]  wsel;
    logic [1:0]         unused_byte_sel;
    logic               req;
    logic               is_store;
    logic               hit;
    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [LINE_W-1:0]  line_data;
    logic               line_we;
    logic               word_we;
    logic               load_hit;
    logic [WORD_W-1:0]  last_data;

    assign req_tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign idx             = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign wsel            = cpu_addr_i[2 +: WSEL_W];
    assign unused_byte_sel = cpu_addr_i[1:0];
    assign req             = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_store        = cpu_MemWrite_i;
    assign hit             = line_valid & (line_tag == req_tag);

    dcache_sram u_sram (
        .clk       (clk_i),
        .rst       (rst_i),
        .idx       (idx),
        .line_we   (line_we),
        .line_tag  (req_tag),
        .line_data (mem_data_i),
        .word_we   (word_we),
        .word_sel  (wsel),
        .word_data (cpu_data_i),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_line   (line_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req && !hit) begin
                    next_state = (line_valid && line_dirty) ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: if (mem_ack_i) next_state = ST_REFILL;
            ST_REFILL:    if (mem_ack_i) next_state = ST_RESUME;
            ST_RESUME:    next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // The missing request is retried in IDLE after RESUME, so only IDLE serves the CPU.
    always_comb begin
        cpu_stall_o = 1'b1;
        word_we     = 1'b0;
        line_we     = 1'b0;
        load_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_stall_o = req & ~hit;
                word_we     = req & hit & is_store;
                load_hit    = req & hit & ~is_store;
            end
            ST_REFILL: line_we = mem_ack_i;
            default: ;
        endcase
        cpu_data_o = load_hit ? select_word(line_data, wsel) : last_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_data <= '0;
        end else if (load_hit) begin
            last_data <= cpu_data_o;
        end
    end

    // Memory outputs are registered from the upcoming state; address/data are
    // captured once on entry so they stay stable for the whole transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            mem_enable_o <= (next_state == ST_WRITEBACK) || (next_state == ST_REFILL);
            mem_write_o  <= (next_state == ST_WRITEBACK);
            if (next_state != state) begin
                if (next_state == ST_WRITEBACK) begin
                    mem_addr_o <= {line_tag, idx, {OFFSET_W{1'b0}}};
                    mem_data_o <= line_data;
                end else if (next_state == ST_REFILL) begin
                    mem_addr_o <= {req_tag, idx, {OFFSET_W{1'b0}}};
                end
            end
        end
    end
endmodule
